// File: rtl/icache_refill_responder_pkg.sv
// ============================================================================
// icache_refill_responder_pkg : shared types and helpers for the refill responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package icache_refill_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int BEAT_BYTES = 4;

   // Number of byte-offset bits covered by one refill line.
   function automatic int line_offset_width(input int line_words);
      return $clog2(line_words) + $clog2(BEAT_BYTES);
   endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_beat_pipe.sv
// ============================================================================
// icache_refill_beat_pipe : one-stage response register aligning beats with mem_rdata
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_refill_beat_pipe #(
   parameter int BEAT_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue_valid,
   input  logic              issue_error,
   input  logic [BEAT_W-1:0] issue_beat,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_error,
   output logic [BEAT_W-1:0] rsp_beat,
   output logic [31:0]       rsp_data
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_beat  <= '0;
      end else begin
         rsp_valid <= issue_valid;
         rsp_error <= issue_valid & issue_error;
         rsp_beat  <= issue_valid ? issue_beat : '0;
      end
   end

   // Memory data arrives in the same cycle the registered beat is presented.
   assign rsp_data = (rsp_valid && !rsp_error) ? mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: rtl/icache_refill_responder.sv
// ============================================================================
// icache_refill_responder : serves instruction-cache line refills from a word memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_refill_responder
   import icache_refill_responder_pkg::*;
#(
   parameter int          LINE_WORDS = 8,
   parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
   parameter int          MEM_WORDS  = 4096
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [31:0]                  cmd_payload_address,
   output logic                         rsp_valid,
   output logic [31:0]                  rsp_payload_data,
   output logic                         rsp_payload_error,
   output logic                         mem_en,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   input  logic [31:0]                  mem_rdata
);

   localparam int          OFF_W     = line_offset_width(LINE_WORDS);
   localparam int          BEAT_W    = $clog2(LINE_WORDS) + 1;
   localparam int          ADDR_W    = $clog2(MEM_WORDS);
   localparam logic [31:0] LINE_MASK = 32'((64'd1 << OFF_W) - 64'd1);
   localparam logic [32:0] SPAN_LO   = {1'b0, MEM_BASE};
   localparam logic [32:0] SPAN_HI   = SPAN_LO + 33'(MEM_WORDS) * 33'(BEAT_BYTES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   state_t              state;
   state_t              state_nxt;
   logic                started;
   logic [BEAT_W-1:0]   beat;
   logic [BEAT_W-1:0]   beat_nxt;
   logic [ADDR_W-1:0]   line_off;
   logic                line_ok;
   logic                issue;
   logic                accept;

   logic [31:0]         cmd_base;
   logic [31:0]         cmd_diff;
   logic                cmd_in_range;
   logic [ADDR_W-1:0]   cmd_word_off;

   logic                pipe_error;
   logic [BEAT_W-1:0]   pipe_beat;

   // 33-bit compare so a line at the very top of the address space does not wrap.
   assign cmd_base     = cmd_payload_address & ~LINE_MASK;
   assign cmd_in_range = ({1'b0, cmd_base} >= SPAN_LO) && ({1'b0, cmd_base} < SPAN_HI);
   assign cmd_diff     = cmd_base - MEM_BASE;
   assign cmd_word_off = ADDR_W'(cmd_diff >> 2);
   assign accept       = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         started  <= 1'b0;
         beat     <= '0;
         line_off <= '0;
         line_ok  <= 1'b0;
      end else begin
         state   <= state_nxt;
         started <= 1'b1;
         beat    <= beat_nxt;
         if (accept) begin
            line_off <= cmd_word_off;
            line_ok  <= cmd_in_range;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      issue     = 1'b0;
      cmd_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = started;
            if (cmd_valid && started) begin
               state_nxt = ISSUE;
               beat_nxt  = '0;
            end
         end
         ISSUE: begin
            issue    = 1'b1;
            beat_nxt = beat + 1'b1;
            if (beat == LAST_BEAT) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave once the final beat is on the response port.
            if (rsp_valid && pipe_beat == LAST_BEAT) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign mem_en   = issue && line_ok;
   assign mem_addr = mem_en ? (line_off + ADDR_W'(beat)) : '0;

   icache_refill_beat_pipe #(
      .BEAT_W (BEAT_W)
   ) u_beat_pipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_valid (issue),
      .issue_error (!line_ok),
      .issue_beat  (beat),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_error   (pipe_error),
      .rsp_beat    (pipe_beat),
      .rsp_data    (rsp_payload_data)
   );

   assign rsp_payload_error = pipe_error;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_responder.sv
// ============================================================================
// tb_icache_refill_responder : randomized bench with a timeline reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid [3];
   logic [31:0] cmd_addr [3];
   logic        cmd_ready [3];
   logic        rsp_valid [3];
   logic [31:0] rsp_data [3];
   logic        rsp_error [3];
   logic        mem_en [3];
   logic [31:0] mem_addr32 [3];
   logic [31:0] mem_rdata [3];
   logic [11:0] ma0;
   logic [9:0]  ma1;
   logic [11:0] ma2;

   logic [31:0] mem [4096];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   // Instance 0: defaults; 1: high memory window; 2: four-beat lines.
   int          acc [3]     = '{0, 0, 0};
   bit          active [3]  = '{0, 0, 0};
   bit          armed [3]   = '{0, 0, 0};
   bit          ok [3]      = '{0, 0, 0};
   int          off [3]     = '{0, 0, 0};
   int          acc_cnt [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   icache_refill_responder u_dut0 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_payload_address(cmd_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_payload_data(rsp_data[0]),
      .rsp_payload_error(rsp_error[0]), .mem_en(mem_en[0]), .mem_addr(ma0), .mem_rdata(mem_rdata[0]));

   icache_refill_responder #(.MEM_BASE(32'hFFFF_F000), .MEM_WORDS(1024)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_payload_address(cmd_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_payload_data(rsp_data[1]),
      .rsp_payload_error(rsp_error[1]), .mem_en(mem_en[1]), .mem_addr(ma1), .mem_rdata(mem_rdata[1]));

   icache_refill_responder #(.LINE_WORDS(4)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
      .cmd_payload_address(cmd_addr[2]), .rsp_valid(rsp_valid[2]), .rsp_payload_data(rsp_data[2]),
      .rsp_payload_error(rsp_error[2]), .mem_en(mem_en[2]), .mem_addr(ma2), .mem_rdata(mem_rdata[2]));

   assign mem_addr32[0] = {20'h0, ma0};
   assign mem_addr32[1] = {22'h0, ma1};
   assign mem_addr32[2] = {20'h0, ma2};

   function automatic int lw_of(input int i);
      return (i == 2) ? 4 : 8;
   endfunction

   function automatic longint mb_of(input int i);
      return (i == 1) ? 64'hFFFF_F000 : 64'h0;
   endfunction

   function automatic longint mw_of(input int i);
      return (i == 1) ? 64'd1024 : 64'd4096;
   endfunction

   // A line occupies acceptance cycle plus LINE_WORDS issue cycles plus one drain cycle.
   function automatic bit model_ready(input int i);
      return armed[i] && (!active[i] || cyc >= acc[i] + lw_of(i) + 2);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         mem_rdata[i] <= mem_en[i] ? mem[mem_addr32[i][11:0]] : $urandom;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            armed[i]  <= 1'b0;
            active[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            armed[i] <= 1'b1;
            if (model_ready(i) && cmd_valid[i]) begin
               longint base;
               base = longint'(cmd_addr[i]) & ~longint'(lw_of(i) * 4 - 1);
               active[i]  <= 1'b1;
               acc[i]     <= cyc;
               ok[i]      <= (base >= mb_of(i)) && (base < mb_of(i) + 4 * mw_of(i));
               off[i]     <= int'((base - mb_of(i)) / 4);
               acc_cnt[i] <= acc_cnt[i] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int          k;
         bit          e_en, e_rv;
         logic [31:0] e_addr, e_data;
         k      = cyc - acc[i];
         e_en   = active[i] && ok[i] && k >= 1 && k <= lw_of(i);
         e_addr = e_en ? 32'(off[i] + k - 1) : 32'h0;
         e_rv   = active[i] && k >= 2 && k <= lw_of(i) + 1;
         e_data = (e_rv && ok[i]) ? mem[off[i] + k - 2] : 32'h0;
         check_val($sformatf("u%0d_cmd_ready", i), {31'h0, cmd_ready[i]}, {31'h0, model_ready(i)});
         check_val($sformatf("u%0d_mem_en", i), {31'h0, mem_en[i]}, {31'h0, e_en});
         check_val($sformatf("u%0d_mem_addr", i), mem_addr32[i], e_addr);
         check_val($sformatf("u%0d_rsp_valid", i), {31'h0, rsp_valid[i]}, {31'h0, e_rv});
         check_val($sformatf("u%0d_rsp_data", i), rsp_data[i], e_data);
         check_val($sformatf("u%0d_rsp_error", i), {31'h0, rsp_error[i]}, {31'h0, e_rv && !ok[i]});
      end
   end

   // Holds cmd_valid until the model has seen n more acceptances, bounded in cycles.
   task automatic hold_accepts(input int i, input logic [31:0] addr, input int n);
      int target;
      target       = acc_cnt[i] + n;
      cmd_addr[i]  = addr;
      cmd_valid[i] = 1'b1;
      for (int c = 0; c < 30 * n && acc_cnt[i] < target; c++) begin
         @(posedge clk);
         #1;
      end
      if (acc_cnt[i] < target)
         check_val($sformatf("u%0d_accept_timeout", i), 32'(acc_cnt[i]), 32'(target));
      #1;
      cmd_valid[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      for (int j = 0; j < 4096; j++) mem[j] = $urandom;
      for (int j = 0; j < 16; j++) mem[j] = 32'(j) * 32'h11;
      for (int i = 0; i < 3; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_addr[i]  = 32'h0;
         mem_rdata[i] = 32'h0;
      end
      idle(3);
      reset_n = 1'b1;
      idle(2);

      hold_accepts(0, 32'h0000_0024, 1);
      hold_accepts(1, 32'hFFFF_FFE0, 1);
      hold_accepts(2, 32'h0000_001C, 1);
      idle(12);
      hold_accepts(0, 32'h8000_0000, 1);
      idle(12);
      hold_accepts(0, 32'h0000_0040, 2);
      idle(12);

      hold_accepts(0, 32'h0000_0100, 1);
      idle(5);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      idle(4);

      for (int r = 0; r < 40; r++) begin
         int          i;
         int          kind;
         logic [31:0] a;
         i    = $urandom_range(0, 2);
         kind = $urandom_range(0, 4);
         case (kind)
            0: a = 32'(mb_of(i) + 4 * longint'($urandom_range(0, 32'(mw_of(i)) - 1)));
            1: a = $urandom;
            2: a = 32'(mb_of(i) - 4);
            3: a = 32'(mb_of(i) + 4 * mw_of(i) - 4);
            default: a = 32'(mb_of(i) + 4 * mw_of(i));
         endcase
         hold_accepts(i, a, 1);
         idle($urandom_range(0, 3));
      end
      idle(25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
